// File: rtl/fpu_div_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_div_arbiter
//
// Shares one fixed-latency pipelined divider between two FPU requesters.
// Requests are arbitrated round-robin and the granted operands are driven
// straight onto the divider inputs. A {valid,id,tag} shift register follows
// each operation through the divider. Results are captured into an in-order
// FIFO so the consumer can apply back-pressure. A credit counter (pending)
// covers everything issued but not yet popped. Issue is refused once that
// counter reaches FDEPTH, so the FIFO can never overflow.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   reqN_valid/reqN_ready    request handshake; ready is the combinational grant
//   reqN_a/reqN_b/reqN_tag   dividend, divisor and opaque tag of requester N
//   div_a/div_b              operands to the shared divider (0 when idle)
//   div_q/div_r/div_dbz      divider results, LAT cycles after the operands
//   rsp_valid/rsp_ready      response handshake at the FIFO head
//   rsp_id/rsp_tag           requester index and tag of the head entry
//   rsp_quot/rsp_rem/rsp_dbz quotient, remainder and divide-by-zero flag
//   busy                     any operation issued and not yet consumed
// ---------------------------------------------------------------------------
module fpu_div_arbiter #(
    parameter int WIDTH  = 27,
    parameter int LAT    = 6,
    parameter int TAGW   = 4,
    parameter int FDEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [TAGW-1:0]  req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [TAGW-1:0]  req1_tag,

    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    input  logic             div_dbz,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAGW-1:0]  rsp_tag,
    output logic [WIDTH-1:0] rsp_quot,
    output logic [WIDTH-1:0] rsp_rem,
    output logic             rsp_dbz,

    output logic             busy
);

    localparam int PW = $clog2(FDEPTH + 1);
    localparam int AW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
    // FIFO entry: {id, tag, quotient, remainder, dbz}
    localparam int EW = 1 + TAGW + 2 * WIDTH + 1;
    localparam logic [PW-1:0] FDEPTH_P = PW'(FDEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(FDEPTH - 1);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [PW-1:0] pending_reg;
    logic          rr_ptr_reg;
    logic          issue_ok;
    logic          grant0;
    logic          grant1;
    logic          issue;
    logic          pop;

    // Credits come from the registered counter only, so a pop releases its
    // slot for issue one cycle later. Grants are masked while reset is held
    // so no handshake can complete during reset.
    assign issue_ok = !rst && (pending_reg < FDEPTH_P);
    assign grant0   = issue_ok && req0_valid && (!req1_valid || !rr_ptr_reg);
    assign grant1   = issue_ok && req1_valid && (!req0_valid ||  rr_ptr_reg);
    assign issue    = grant0 || grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        div_a = '0;
        div_b = '0;
        if (grant0) begin
            div_a = req0_a;
            div_b = req0_b;
        end else if (grant1) begin
            div_a = req1_a;
            div_b = req1_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= 1'b0;
        end else if (issue) begin
            // The side that just won loses priority next time.
            rr_ptr_reg <= grant0;
        end
    end

    // ------------------------------------------------------------------
    // In-flight tracking, aligned with the divider pipeline: the last stage
    // is valid in the same cycle as the matching div_q/div_r/div_dbz.
    // ------------------------------------------------------------------
    logic [LAT-1:0]           trk_valid_reg;
    logic [LAT-1:0]           trk_id_reg;
    logic [LAT-1:0][TAGW-1:0] trk_tag_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk_valid_reg <= '0;
            trk_id_reg    <= '0;
            trk_tag_reg   <= '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                trk_valid_reg[i] <= trk_valid_reg[i-1];
                trk_id_reg[i]    <= trk_id_reg[i-1];
                trk_tag_reg[i]   <= trk_tag_reg[i-1];
            end
            trk_valid_reg[0] <= issue;
            trk_id_reg[0]    <= grant1;
            trk_tag_reg[0]   <= grant1 ? req1_tag : (grant0 ? req0_tag : '0);
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    logic [AW-1:0]              wr_ptr_reg;
    logic [AW-1:0]              rd_ptr_reg;
    logic [PW-1:0]              fifo_cnt_reg;
    logic                       fifo_wr;
    logic [EW-1:0]              wr_entry;
    logic [FDEPTH-1:0][EW-1:0]  fifo_mem;
    logic [EW-1:0]              head_entry;

    assign fifo_wr  = trk_valid_reg[LAT-1];
    assign wr_entry = {trk_id_reg[LAT-1], trk_tag_reg[LAT-1], div_q, div_r, div_dbz};
    assign pop      = rsp_valid && rsp_ready;

    genvar gi;
    generate
        for (gi = 0; gi < FDEPTH; gi++) begin : g_fifo_entry
            logic [EW-1:0] entry_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (fifo_wr && (wr_ptr_reg == AW'(gi))) begin
                    entry_reg <= wr_entry;
                end
            end

            assign fifo_mem[gi] = entry_reg;
        end
    endgenerate

    // Head reads storage only, so an entry written this cycle is visible at
    // the head no earlier than the next cycle.
    assign head_entry = fifo_mem[rd_ptr_reg];
    assign {rsp_id, rsp_tag, rsp_quot, rsp_rem, rsp_dbz} = head_entry;
    assign rsp_valid = (fifo_cnt_reg != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_IDX) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_IDX) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({fifo_wr, pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Credit counter: covers ops in the divider plus entries in the FIFO.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   pending_reg <= pending_reg + 1'b1;
                2'b01:   pending_reg <= pending_reg - 1'b1;
                default: pending_reg <= pending_reg;
            endcase
        end
    end

    assign busy = (pending_reg != '0);

endmodule
